// File: rtl/level_pkg.sv
// Shared definitions for the level tile RAM/ROM: geometry, command opcodes
// and the single address map used by both the renderer-side reader and the
// loader-side writer.
package level_pkg;

  localparam int unsigned LEVEL_COLS   = 256;
  localparam int unsigned LEVEL_ROWS   = 16;
  localparam int unsigned LEVEL_TILE_W = 6;
  localparam int unsigned LEVEL_COL_W  = $clog2(LEVEL_COLS);
  localparam int unsigned LEVEL_ROW_W  = $clog2(LEVEL_ROWS);
  localparam int unsigned LEVEL_ADDR_W = LEVEL_COL_W + LEVEL_ROW_W;

  typedef enum logic [1:0] {
    OP_WRITE_ONE = 2'd0,
    OP_FILL      = 2'd1,
    OP_LOAD      = 2'd2,
    OP_RSVD      = 2'd3
  } level_op_t;

  // Tile RAM address {col[7:4], row, col[3:0]}; 16-column blocks are contiguous.
  function automatic logic [LEVEL_ADDR_W-1:0] level_addr(
    input logic [LEVEL_COL_W-1:0] col,
    input logic [LEVEL_ROW_W-1:0] row
  );
    return {col[LEVEL_COL_W-1:4], row, col[3:0]};
  endfunction

endpackage

// File: rtl/level_scan_counter.sv
// Column-major scan position for the level writer.
//   load/ld_col/ld_row/ld_len : start position and (columns - 1) to scan
//   step                      : advance one row, wrapping into the next column
//   col/row                   : current scan position (registered)
//   last                      : current position is the final one of the scan
//   last_next                 : the next step lands on the final position
module level_scan_counter
  import level_pkg::*;
#(
  parameter int unsigned COL_W = LEVEL_COL_W,
  parameter int unsigned ROW_W = LEVEL_ROW_W
) (
  input  logic             vclock,
  input  logic             reset,
  input  logic             load,
  input  logic [COL_W-1:0] ld_col,
  input  logic [ROW_W-1:0] ld_row,
  input  logic [COL_W-1:0] ld_len,
  input  logic             step,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last,
  output logic             last_next
);

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'((1 << ROW_W) - 1);

  logic [COL_W-1:0] remaining;

  // Column index wraps naturally modulo 2**COL_W.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      remaining <= '0;
    end else if (load) begin
      col       <= ld_col;
      row       <= ld_row;
      remaining <= ld_len;
    end else if (step) begin
      if (row == ROW_MAX) begin
        row       <= '0;
        col       <= col + COL_W'(1);
        remaining <= remaining - COL_W'(1);
      end else begin
        row <= row + ROW_W'(1);
      end
    end
  end

  assign last      = (row == ROW_MAX) && (remaining == '0);
  assign last_next = (row == ROW_MAX - ROW_W'(1)) && (remaining == '0);

endmodule

// File: rtl/level_tile_writer.sv
// Write-side controller for the 4096 x 6-bit level tile RAM.
// Executes WRITE_ONE, FILL (constant tile over a column range) and LOAD
// (valid/ready tile stream over a column range) commands, column-major.
//   vclock, reset                 : clock, async active-high reset
//   cmd_valid/cmd_ready/cmd_*     : command channel, accepted only when idle
//   in_valid/in_ready/in_tile     : LOAD tile stream
//   abort                         : stops a FILL/LOAD after the write in flight
//   ram_we/ram_addr/ram_din       : registered RAM write port
//   busy, done                    : status; done pulses with the final write
module level_tile_writer
  import level_pkg::*;
#(
  parameter int unsigned COL_W  = LEVEL_COL_W,
  parameter int unsigned ROW_W  = LEVEL_ROW_W,
  parameter int unsigned TILE_W = LEVEL_TILE_W
) (
  input  logic                   vclock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [COL_W-1:0]       cmd_column,
  input  logic [ROW_W-1:0]       cmd_row,
  input  logic [COL_W-1:0]       cmd_len,
  input  logic [TILE_W-1:0]      cmd_tile,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TILE_W-1:0]      in_tile,
  input  logic                   abort,
  output logic                   ram_we,
  output logic [COL_W+ROW_W-1:0] ram_addr,
  output logic [TILE_W-1:0]      ram_din,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FILL  = 2'd2,
    ST_LOAD  = 2'd3
  } state_t;

  state_t           state;
  logic             started;   // LOAD: first tile already written at the start position
  logic             cnt_load;
  logic             cnt_step;
  logic [ROW_W-1:0] ld_row;
  logic [COL_W-1:0] scan_col;
  logic [ROW_W-1:0] scan_row;
  logic             scan_last;
  logic             scan_last_next;
  logic             load_hs;

  // The scan counter always holds the position of the write on the RAM bus,
  // so the first FILL/LOAD write uses the loaded position without a step.
  assign cnt_load = (state == ST_IDLE) && cmd_valid;
  assign ld_row   = (level_op_t'(cmd_op) == OP_WRITE_ONE) ? cmd_row : '0;
  assign load_hs  = (state == ST_LOAD) && in_valid && in_ready && !abort && !done;
  assign cnt_step = ((state == ST_FILL) && !done && !abort) || (load_hs && started);

  level_scan_counter #(
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_scan (
    .vclock    (vclock),
    .reset     (reset),
    .load      (cnt_load),
    .ld_col    (cmd_column),
    .ld_row    (ld_row),
    .ld_len    (cmd_len),
    .step      (cnt_step),
    .col       (scan_col),
    .row       (scan_row),
    .last      (scan_last),
    .last_next (scan_last_next)
  );

  // Address is a pure rewiring of the scan counter flops.
  assign ram_addr = level_addr(scan_col, scan_row);

  // Command FSM; in FILL/LOAD a high done marks the closing cycle before IDLE.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      ram_we    <= 1'b0;
      ram_din   <= '0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
      started   <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (level_op_t'(cmd_op))
              OP_WRITE_ONE: begin
                state     <= ST_WRITE;
                ram_we    <= 1'b1;
                ram_din   <= cmd_tile;
                done      <= 1'b1;
                busy      <= 1'b1;
                cmd_ready <= 1'b0;
              end
              OP_FILL: begin
                state     <= ST_FILL;
                ram_we    <= 1'b1;
                ram_din   <= cmd_tile;
                busy      <= 1'b1;
                cmd_ready <= 1'b0;
              end
              OP_LOAD: begin
                state     <= ST_LOAD;
                in_ready  <= 1'b1;
                started   <= 1'b0;
                busy      <= 1'b1;
                cmd_ready <= 1'b0;
              end
              default: begin
                done <= 1'b1;
              end
            endcase
          end
        end
        ST_WRITE: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        ST_FILL: begin
          if (done) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else if (abort) begin
            done <= 1'b1;
          end else begin
            ram_we <= 1'b1;
            done   <= scan_last_next;
          end
        end
        ST_LOAD: begin
          if (done) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else if (abort) begin
            done     <= 1'b1;
            in_ready <= 1'b0;
          end else if (in_valid && in_ready) begin
            ram_we  <= 1'b1;
            ram_din <= in_tile;
            started <= 1'b1;
            // Final tile: stop accepting and flag completion with its write.
            if (started ? scan_last_next : scan_last) begin
              done     <= 1'b1;
              in_ready <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
